// File: rtl/prog_cache_ctrl_pkg.sv
// Shared geometry constants and FSM state type for the program cache controller.
package prog_cache_ctrl_pkg;

    localparam int LINES    = 16;
    localparam int WORDS    = 4;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 4;
    localparam int TAG_W    = 7;
    localparam int PC_W     = OFFSET_W + INDEX_W + TAG_W;
    localparam int LINE_W   = PC_W - OFFSET_W;
    localparam int DATA_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pcache_tag_ram.sv
// Valid bits and tags for the direct-mapped program cache; valid bits clear on reset and flush.
module pcache_tag_ram
    import prog_cache_ctrl_pkg::*;
#(
    parameter int N_LINES = 16
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               flush_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic               wr_valid_i
);

    logic [N_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [N_LINES];

    // A flush on the same edge as a line write wins: the written line stays invalid.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end
        if (wr_en_i) begin
            valid_d[wr_index_i] = wr_valid_i & ~flush_i;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];

endmodule

// File: rtl/prog_cache_ctrl.sv
// Direct-mapped instruction cache with in-order line fill from external ROM.
// Define PCACHE_STATS_EN to add the saturating miss_count output.
//
// state | meaning
// IDLE  | serving hits combinationally; a miss starts a fill
// FILL  | fetching WORDS words of the latched line from ROM, offset 0 first
module prog_cache_ctrl
    import prog_cache_ctrl_pkg::*;
#(
    parameter int LINES = prog_cache_ctrl_pkg::LINES,
    parameter int WORDS = prog_cache_ctrl_pkg::WORDS
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [PC_W-1:0]   PC,
    input  logic              flush,
    output logic [DATA_W-1:0] I,
    output logic              p_cache_miss,
    output logic              rom_req,
    output logic [PC_W-1:0]   rom_addr,
    input  logic              rom_ack,
`ifdef PCACHE_STATS_EN
    input  logic [DATA_W-1:0] rom_data,
    output logic [15:0]       miss_count
`else
    input  logic [DATA_W-1:0] rom_data
`endif
);

    pc_state_e           state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]     addr_q, addr_d;
    logic                flushed_q, flushed_d;

    logic [DATA_W-1:0]   data_q [LINES*WORDS];

    logic [INDEX_W-1:0]  pc_index;
    logic [TAG_W-1:0]    pc_tag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic                hit;
    logic                fill_ack;
    logic                last_ack;

    assign pc_index = PC[OFFSET_W +: INDEX_W];
    assign pc_tag   = PC[OFFSET_W+INDEX_W +: TAG_W];

    pcache_tag_ram #(
        .N_LINES (LINES)
    ) u_tag_ram (
        .clk        (clk),
        .RST        (RST),
        .flush_i    (flush),
        .rd_index_i (pc_index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .wr_en_i    (last_ack),
        .wr_index_i (line_q[INDEX_W-1:0]),
        .wr_tag_i   (line_q[LINE_W-1 -: TAG_W]),
        .wr_valid_i (~flushed_q)
    );

    assign hit          = (state_q == IDLE) && rd_valid && (rd_tag == pc_tag);
    assign p_cache_miss = ~hit;
    assign fill_ack     = (state_q == FILL) && rom_ack;
    assign last_ack     = fill_ack && (cnt_q == OFFSET_W'(WORDS-1));
    assign rom_req      = (state_q == FILL);
    assign rom_addr     = addr_q;
    assign I            = data_q[PC[OFFSET_W+INDEX_W-1:0]];

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        flushed_d = flushed_q;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    state_d   = FILL;
                    line_d    = PC[PC_W-1:OFFSET_W];
                    cnt_d     = '0;
                    addr_d    = {PC[PC_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    flushed_d = 1'b0;
                end
            end
            FILL: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (rom_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_ack) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = {line_q, cnt_q + 1'b1};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= IDLE;
            line_q    <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            flushed_q <= flushed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_ack) begin
            data_q[{line_q[INDEX_W-1:0], cnt_q}] <= rom_data;
        end
    end

`ifdef PCACHE_STATS_EN
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            miss_cnt_q <= '0;
        end else if ((state_q == IDLE) && !hit && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign miss_count = miss_cnt_q;
`endif

endmodule
